// File: rtl/cmp_scan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : cmp_scan_pkg                                              |
// | Brief  : Shared types and constants for the streaming max/min/     |
// |          count scanner (FSM states, sel codes, uio bit positions). |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
package cmp_scan_pkg;

  // Scanner sequencing: one idle state plus two comparator time slots.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CMP_MAX = 2'b01,
    ST_CMP_MIN = 2'b10
  } state_e;

  // Result selection codes on uio_in[4:3].
  localparam logic [1:0] SEL_MAX    = 2'b00;
  localparam logic [1:0] SEL_MIN    = 2'b01;
  localparam logic [1:0] SEL_COUNT  = 2'b10;
  localparam logic [1:0] SEL_SAMPLE = 2'b11;

  // uio_in control bit positions.
  localparam int UIO_STROBE = 0;
  localparam int UIO_FIRST  = 1;
  localparam int UIO_LAST   = 2;
  localparam int UIO_SEL_LO = 3;
  localparam int UIO_SEL_HI = 4;

  // uio_out status bit positions.
  localparam int UIO_BUSY = 5;
  localparam int UIO_DONE = 6;
  localparam int UIO_DROP = 7;

  // Only the three status bits are driven onto the bidirectional pins.
  localparam logic [7:0] UIO_OE_MASK = 8'b1110_0000;

endpackage
`default_nettype wire

// File: rtl/mag_cmp8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : mag_cmp8                                                  |
// | Brief  : Unsigned 8-bit magnitude comparator (a vs b).             |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module mag_cmp8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);

  // Exactly one of lt/eq/gt is high for any operand pair.
  assign lt = (a <  b);
  assign eq = (a == b);
  assign gt = (a >  b);

endmodule
`default_nettype wire

// File: rtl/cmp_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : cmp_scan_ctrl                                             |
// | Brief  : Tracks running max, min and sample count over a strobed   |
// |          byte stream using a single time-shared comparator.        |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module cmp_scan_ctrl
  import cmp_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e     state_q;
  logic       strobe_q;
  logic       first_q;
  logic       last_q;
  logic       busy_q;
  logic       done_q;
  logic       drop_q;
  logic [7:0] sample_q;
  logic [7:0] max_q;
  logic [7:0] min_q;
  logic [7:0] count_q;
  logic [7:0] count_d;

  logic       strobe_rise;
  logic       accept;
  logic       first_in;
  logic       last_in;
  logic [1:0] sel;
  logic [7:0] cmp_b;
  logic       cmp_lt;
  logic       cmp_eq;
  logic       cmp_gt;
  logic       unused_bits;

  assign first_in    = uio_in[UIO_FIRST];
  assign last_in     = uio_in[UIO_LAST];
  assign sel         = uio_in[UIO_SEL_HI:UIO_SEL_LO];
  assign strobe_rise = uio_in[UIO_STROBE] & ~strobe_q;
  assign accept      = strobe_rise & ena & (state_q == ST_IDLE);

  // eq needs no explicit handling: ties fall through to "hold" below.
  assign unused_bits = ^{uio_in[7:5], cmp_eq};

  // Count restarts on a first sample, otherwise saturates at 255.
  assign count_d = first_in             ? 8'd1    :
                   (count_q == 8'hFF)   ? count_q :
                                          count_q + 8'd1;

  // The single comparator sees max in CMP_MAX and min in CMP_MIN.
  assign cmp_b = (state_q == ST_CMP_MIN) ? min_q : max_q;

  mag_cmp8 u_cmp (
    .a  (sample_q),
    .b  (cmp_b),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  // Edge-detect history for the strobe, sampled unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) strobe_q <= 1'b0;
    else        strobe_q <= uio_in[UIO_STROBE];
  end

  // Sticky drop flag: any strobe edge that cannot be accepted sets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else if (accept && first_in) begin
      drop_q <= 1'b0;
    end else if (strobe_rise && (busy_q || !ena)) begin
      drop_q <= 1'b1;
    end
  end

  // Sequencer and datapath: capture, then max slot, then min slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      sample_q <= 8'h00;
      max_q    <= 8'h00;
      min_q    <= 8'hFF;
      count_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            sample_q <= ui_in;
            first_q  <= first_in;
            last_q   <= last_in;
            count_q  <= count_d;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_CMP_MAX;
          end
        end
        ST_CMP_MAX: begin
          if (first_q || cmp_gt) max_q <= sample_q;
          state_q <= ST_CMP_MIN;
        end
        ST_CMP_MIN: begin
          if (first_q || cmp_lt) min_q <= sample_q;
          if (last_q) done_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Result byte selection straight from the registers.
  always_comb begin
    uo_out = max_q;
    case (sel)
      SEL_MAX:    uo_out = max_q;
      SEL_MIN:    uo_out = min_q;
      SEL_COUNT:  uo_out = count_q;
      SEL_SAMPLE: uo_out = sample_q;
      default:    uo_out = max_q;
    endcase
  end

  // Status byte: only the top three bits carry information.
  always_comb begin
    uio_out           = 8'h00;
    uio_out[UIO_BUSY] = busy_q;
    uio_out[UIO_DONE] = done_q;
    uio_out[UIO_DROP] = drop_q;
  end

  assign uio_oe = UIO_OE_MASK;

endmodule
`default_nettype wire

// File: tb/tb_cmp_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_cmp_scan_ctrl                                          |
// | Brief  : Self-checking bench for cmp_scan_ctrl with a timestamp-   |
// |          based reference model and directed plus random stimulus.  |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cmp_scan_ctrl;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b1;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  cmp_scan_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted sample is stamped with its edge number; max becomes
  // visible one edge later, min and done two edges later, and the block
  // is busy for the two edges following the capture.
  bit         m_prev   = 0;
  logic [7:0] m_max    = 8'h00;
  logic [7:0] m_min    = 8'hFF;
  logic [7:0] m_sample = 8'h00;
  int         m_cnt    = 0;
  bit         m_done   = 0;
  bit         m_drop   = 0;
  bit         m_busy   = 0;
  bit         m_have   = 0;
  bit         m_last   = 0;
  int         m_acc    = 0;
  int         m_edge   = 0;
  logic [7:0] m_nmax   = 8'h00;
  logic [7:0] m_nmin   = 8'hFF;

  always @(posedge clk or negedge rst_n) begin
    bit s, rise, f, l;
    logic [7:0] x;
    int n;
    if (!rst_n) begin
      m_prev = 0; m_max = 8'h00; m_min = 8'hFF; m_sample = 8'h00;
      m_cnt = 0; m_done = 0; m_drop = 0; m_busy = 0; m_have = 0;
      m_last = 0; m_edge = 0;
    end else begin
      s = uio_in[0]; f = uio_in[1]; l = uio_in[2]; x = ui_in;
      rise = s && !m_prev;
      m_prev = s;
      n = m_edge + 1;
      if (m_have && n == m_acc + 1) m_max = m_nmax;
      if (m_have && n == m_acc + 2) begin
        m_min = m_nmin;
        if (m_last) m_done = 1;
      end
      if (rise) begin
        if (m_busy || !ena) begin
          m_drop = 1;
        end else begin
          m_acc = n; m_have = 1; m_sample = x; m_last = l; m_done = 0;
          m_nmax = (f || x > m_max) ? x : m_max;
          m_nmin = (f || x < m_min) ? x : m_min;
          m_cnt  = f ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
          if (f) m_drop = 0;
        end
      end
      m_edge = n;
      m_busy = m_have && (n == m_acc || n == m_acc + 1);
    end
  end

  function automatic logic [7:0] exp_uo(input logic [1:0] s);
    case (s)
      2'b00:   return m_max;
      2'b01:   return m_min;
      2'b10:   return 8'(m_cnt);
      default: return m_sample;
    endcase
  endfunction

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      check("uo_out",  uo_out,  exp_uo(uio_in[4:3]));
      check("uio_out", uio_out, {m_drop, m_done, m_busy, 5'b00000});
      check("uio_oe",  uio_oe,  8'hE0);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [1:0] sel_v = 2'b00;

  task automatic set_ctrl(input bit s, input bit f, input bit l);
    uio_in = {3'b000, sel_v, l, f, s};
  endtask

  task automatic pulse(input logic [7:0] x, input bit f, input bit l);
    @(negedge clk);
    ui_in = x;
    set_ctrl(1'b1, f, l);
    @(negedge clk);
    set_ctrl(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic peek(input string name, input logic [1:0] s, input logic [7:0] exp);
    sel_v = s;
    uio_in[4:3] = s;
    #1;
    check(name, uo_out, exp);
  endtask

  logic [7:0] last_x;

  initial begin
    // Reset state
    idle(3);
    peek("rst_max", 2'b00, 8'h00);
    peek("rst_min", 2'b01, 8'hFF);
    peek("rst_cnt", 2'b10, 8'h00);
    check("rst_status", uio_out[7:5], 8'h00);
    check("rst_oe", uio_oe, 8'hE0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);
    peek("post_rst_min", 2'b01, 8'hFF);

    // Basic stream
    pulse(8'h40, 1, 0); idle(2);
    pulse(8'h10, 0, 0); idle(2);
    pulse(8'h90, 0, 0); idle(2);
    pulse(8'h90, 0, 1);
    check("busy_k",   uio_out[5], 8'd1);
    idle(1);
    check("busy_k1",  uio_out[5], 8'd1);
    check("done_k1",  uio_out[6], 8'd0);
    idle(1);
    check("busy_k2",  uio_out[5], 8'd0);
    check("done_k2",  uio_out[6], 8'd1);
    peek("s_max", 2'b00, 8'h90);
    peek("s_min", 2'b01, 8'h10);
    peek("s_cnt", 2'b10, 8'h04);
    check("model_max", m_max, 8'h90);
    check("model_min", m_min, 8'h10);

    // Strobe edge while busy is dropped
    pulse(8'h20, 1, 0);
    @(negedge clk);
    ui_in = 8'h55;
    set_ctrl(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_ctrl(1'b0, 1'b0, 1'b0);
    idle(3);
    check("drop_set", uio_out[7], 8'd1);
    peek("drop_cnt", 2'b10, 8'h01);
    peek("drop_smp", 2'b11, 8'h20);
    pulse(8'h33, 1, 0); idle(3);
    check("drop_clr", uio_out[7], 8'd0);

    // Single first+last sample
    pulse(8'h7F, 1, 1); idle(2);
    peek("fl_max", 2'b00, 8'h7F);
    peek("fl_min", 2'b01, 8'h7F);
    peek("fl_cnt", 2'b10, 8'h01);
    check("fl_done", uio_out[6], 8'd1);
    pulse(8'h05, 0, 0);
    check("done_clr", uio_out[6], 8'd0);
    idle(3);

    // Strobe with ena low is dropped
    @(negedge clk); ena = 1'b0;
    pulse(8'h11, 0, 0); idle(2);
    check("ena_drop", uio_out[7], 8'd1);
    @(negedge clk); ena = 1'b1;

    // Count saturation
    pulse(8'h01, 1, 0); idle(2);
    last_x = 8'h00;
    for (int i = 0; i < 300; i++) begin
      last_x = 8'($urandom);
      pulse(last_x, 0, 0);
      idle(2);
    end
    peek("sat_cnt", 2'b10, 8'hFF);
    peek("sat_smp", 2'b11, last_x);

    // Reset during CMP_MAX
    pulse(8'hC8, 1, 0);
    rst_n = 1'b0;
    #1;
    check("rst_busy", uio_out[5], 8'd0);
    peek("rst_mid_max", 2'b00, 8'h00);
    peek("rst_mid_min", 2'b01, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ena    = ($urandom_range(0, 7) != 0);
      ui_in  = 8'($urandom);
      uio_in = {3'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0)};
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
